vector_cmd_fifo: RTL and testbench
==================================

VECTOR_CMD_FIFO -- requirements
Module: vector_cmd_fifo

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port wr_en, input, 1: push one command this cycle.
REQ-004 SHALL have port wr_x, input, 12: target X of the pushed command.
REQ-005 SHALL have port wr_y, input, 12: target Y of the pushed command.
REQ-006 SHALL have port wr_draw, input, 1: 1 = beam-on draw to target; 0 = beam-off jump.
REQ-007 SHALL have port full, output, 1: FIFO holds 16 entries.
REQ-008 SHALL have port level, output, 5: entry count, 0..16.
REQ-009 SHALL have port overflow, output, 1: sticky flag, push attempted while full.
REQ-010 SHALL have port ready, input, 1: downstream line drawer can accept a command.
REQ-011 SHALL have port x, output, 12: target X presented to the drawer.
REQ-012 SHALL have port y, output, 12: target Y presented to the drawer.
REQ-013 SHALL have port draw, output, 1: one-cycle draw-command pulse.
REQ-014 SHALL have port jump, output, 1: one-cycle jump-command pulse.

Function
REQ-015 SHALL store commands as 25-bit entries {draw, x, y} in a 16-deep FIFO with 4-bit wrapping read/write pointers.
REQ-016 SHALL write the entry on wr_en when not full; the entry becomes issuable no earlier than the following cycle (no fall-through).
REQ-017 SHALL drop a push while full, even if a pop occurs in the same cycle, and SHALL set overflow, which holds until reset.
REQ-018 SHALL implement the issue FSM with states IDLE, ISSUE and HOLD.
REQ-019 In IDLE with level>0 and ready=1 at the clock edge, SHALL pop the head entry, register its x/y onto x/y, and enter ISSUE.
REQ-020 In ISSUE, SHALL drive draw=1 if the entry's draw bit is 1, else jump=1; it SHALL NOT assert both together and SHALL keep the pulse exactly one cycle; it SHALL then enter HOLD.
REQ-021 In HOLD, SHALL drive draw=jump=0, ignore ready for that one cycle (drawer deassertion latency), then return to IDLE.
REQ-022 SHALL accept at most one command per 3 cycles.
REQ-023 SHALL hold x/y at the last issued values between commands.
REQ-024 SHALL count level as +1 on an accepted push, -1 on a pop, unchanged when both occur in the same cycle.
REQ-025 SHALL raise full combinationally from level==16.
REQ-026 With level 0, SHALL leave the FSM in IDLE and issue nothing, regardless of ready.

Reset
REQ-027 On reset=1 at a clock edge, SHALL set pointers=0, level=0, overflow=0, x=y=0, draw=jump=0 and FSM=IDLE, in any state, including mid-ISSUE (pulse cut) and mid-HOLD.
REQ-028 SHALL discard FIFO contents on reset and SHALL ignore a wr_en asserted in the reset cycle.

Configuration
REQ-029 SHALL gate a park feature with macro VECTOR_CMD_FIFO_PARK_EN.
REQ-030 With VECTOR_CMD_FIFO_PARK_EN defined, after level has been 0 with the FSM in IDLE for 256 consecutive cycles, SHALL issue one jump to (2048,2048) via the ISSUE/HOLD sequence when ready=1.
REQ-031 With VECTOR_CMD_FIFO_PARK_EN defined, the park SHALL be issued at most once per empty period, and any push SHALL clear the idle counter and park-done flag.
REQ-032 With VECTOR_CMD_FIFO_PARK_EN undefined, SHALL have no idle counter and SHALL never issue an unsolicited command.

Verification
REQ-033 SHALL cover: push (100,200,draw=1) with ready=1 held -> draw high exactly 1 cycle, 2 cycles after wr_en, with x=100, y=200; jump stays 0.
REQ-034 SHALL cover: push 3 jumps with ready=1 -> jump pulses 3 cycles apart; level 3,2,1,0 decrementing at each issue.
REQ-035 SHALL cover: push 17 entries with ready=0 -> full=1 at 16, the 17th is dropped, overflow=1; releasing ready drains exactly the first 16 in order.
REQ-036 SHALL cover: reset during ISSUE with 5 queued -> the next cycle has draw=jump=0, level=0, x=y=0, and no further pulses.
REQ-037 SHALL cover: push and pop in the same cycle at level 8 -> level stays 8.
REQ-038 SHALL cover, with PARK_EN: empty for 256 cycles with ready=1 -> a single jump to (2048,2048), and no second jump after a further 1000 idle cycles.

Source files
------------

// File: rtl/vector_cmd_fifo.sv
// vector_cmd_fifo: 16-deep vector command FIFO with a 3-cycle IDLE/ISSUE/HOLD issue FSM.
// Define VECTOR_CMD_FIFO_PARK_EN to park the beam at (2048,2048) after 256 empty idle cycles.
module vector_cmd_fifo (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [11:0] wr_x,
  input  logic [11:0] wr_y,
  input  logic        wr_draw,
  output logic        full,
  output logic [4:0]  level,
  output logic        overflow,
  input  logic        ready,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        draw,
  output logic        jump
);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t      state;
  logic [24:0] mem [16];
  logic [3:0]  wp, rp;
  logic [24:0] head;
  logic        push, pop, park;
  assign full = level == 5'd16;
  assign push = wr_en && !full && !reset;
  assign pop  = state == IDLE && level != 5'd0 && ready;
  assign head = mem[rp];
`ifdef VECTOR_CMD_FIFO_PARK_EN
  logic [8:0] idle_cnt;
  logic       park_done;
  assign park = state == IDLE && level == 5'd0 && ready && !park_done && idle_cnt == 9'd256;
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt  <= '0;
      park_done <= 1'b0;
    end else begin
      idle_cnt  <= (push || state != IDLE || level != 5'd0) ? 9'd0 :
                   idle_cnt + {8'd0, idle_cnt != 9'd256};
      park_done <= push ? 1'b0 : park_done | park;
    end
  end
`else
  assign park = 1'b0;
`endif
  always_ff @(posedge clk)
    if (push) mem[wp] <= {wr_draw, wr_x, wr_y};
  always_ff @(posedge clk) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      overflow <= 1'b0;
      x        <= '0;
      y        <= '0;
      draw     <= 1'b0;
      jump     <= 1'b0;
      state    <= IDLE;
    end else begin
      if (push) wp <= wp + 4'd1;
      if (pop) rp <= rp + 4'd1;
      level    <= level + {4'd0, push} - {4'd0, pop};
      overflow <= overflow | (wr_en & full);
      case (state)
        IDLE: begin
          if (pop) begin
            x     <= head[23:12];
            y     <= head[11:0];
            draw  <= head[24];
            jump  <= !head[24];
            state <= ISSUE;
          end else if (park) begin
            x     <= 12'd2048;
            y     <= 12'd2048;
            jump  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          draw  <= 1'b0;
          jump  <= 1'b0;
          state <= HOLD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_cmd_fifo.sv
// tb_vector_cmd_fifo: directed and random stimulus against a queue-based reference model.
module tb_vector_cmd_fifo;
  logic        clk = 1'b0;
  logic        reset, wr_en, wr_draw, ready;
  logic [11:0] wr_x, wr_y, x, y;
  logic        full, overflow, draw, jump;
  logic [4:0]  level;
  logic [24:0] q[$];
  int          cool, idle, checks, errors, pulses;
  bit          pdone;
  logic [11:0] ex, ey;
  logic        ed, ej, eovf;

  vector_cmd_fifo dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_draw(wr_draw),
    .full(full), .level(level), .overflow(overflow), .ready(ready),
    .x(x), .y(y), .draw(draw), .jump(jump)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advances one clock; the model decides pops/pushes from pre-edge inputs and occupancy.
  task automatic tick();
    bit pop_m, push_m, park_m, empty_idle;
    logic [24:0] e;
    empty_idle = cool == 0 && q.size() == 0;
    pop_m  = !reset && cool == 0 && q.size() > 0 && ready;
    push_m = !reset && wr_en && q.size() < 16;
`ifdef VECTOR_CMD_FIFO_PARK_EN
    park_m = !reset && empty_idle && ready && !pdone && idle >= 256;
`else
    park_m = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      cool = 0; idle = 0; pdone = 0;
      ex = 0; ey = 0; ed = 0; ej = 0; eovf = 0;
    end else begin
      eovf = eovf | (wr_en && q.size() == 16);
      if (push_m) begin idle = 0; pdone = 0; end
      else if (empty_idle) idle = idle < 256 ? idle + 1 : idle;
      else idle = 0;
      if (park_m) pdone = 1;
      ed = 0; ej = 0;
      if (pop_m) begin
        e = q.pop_front();
        ex = e[23:12]; ey = e[11:0]; ed = e[24]; ej = !e[24]; cool = 2;
      end else if (park_m) begin
        ex = 12'd2048; ey = 12'd2048; ej = 1; cool = 2;
      end else if (cool > 0) cool--;
      if (push_m) q.push_back({wr_draw, wr_x, wr_y});
    end
    if (draw || jump) pulses++;
    check("draw", draw, ed);
    check("jump", jump, ej);
    check("x", x, ex);
    check("y", y, ey);
    check("level", level, q.size());
    check("full", full, q.size() == 16);
    check("overflow", overflow, eovf);
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic push(input logic [11:0] px, input logic [11:0] py, input logic pd);
    wr_en = 1; wr_x = px; wr_y = py; wr_draw = pd;
    tick();
    wr_en = 0;
  endtask

  initial begin
    checks = 0; errors = 0; pulses = 0;
    reset = 1; wr_en = 0; wr_x = 0; wr_y = 0; wr_draw = 0; ready = 0;
    tick(); tick();
    reset = 0;
    check("reset_level", level, 0);
    check("reset_draw", draw, 0);

    // Single draw with ready held: pulse two cycles after wr_en.
    ready = 1;
    push(12'd100, 12'd200, 1'b1);
    check("d1_level", level, 1);
    check("d1_draw_early", draw, 0);
    tick();
    check("d1_draw", draw, 1);
    check("d1_jump", jump, 0);
    check("d1_x", x, 100);
    check("d1_y", y, 200);
    tick();
    check("d1_draw_end", draw, 0);
    repeat (4) tick();

    // Three jumps: pulses 3 cycles apart, level stepping down.
    ready = 0;
    for (int i = 0; i < 3; i++) push(12'(10 * i), 12'(20 * i), 1'b0);
    check("j3_level", level, 3);
    ready = 1;
    pulses = 0;
    repeat (9) tick();
    check("j3_pulses", pulses, 3);
    check("j3_empty", level, 0);
    repeat (3) tick();

    // Fill past full with ready low, then drain in order.
    ready = 0;
    for (int i = 0; i < 17; i++) push(12'(i + 1), 12'(100 + i), 1'(i & 1));
    check("fill_full", full, 1);
    check("fill_ovf", overflow, 1);
    ready = 1;
    pulses = 0;
    repeat (52) tick();
    check("drain_pulses", pulses, 16);
    check("drain_x", x, 16);
    check("ovf_sticky", overflow, 1);

    // Reset mid-ISSUE with five left queued; wr_en in the reset cycle is ignored.
    do_reset();
    ready = 0;
    for (int i = 0; i < 6; i++) push(12'(i + 7), 12'(i + 9), 1'b1);
    ready = 1;
    tick();
    check("mid_issue", draw, 1);
    check("mid_level", level, 5);
    reset = 1; wr_en = 1; wr_x = 12'd55; wr_y = 12'd66; wr_draw = 1'b1;
    tick();
    reset = 0; wr_en = 0;
    check("rst_draw", draw, 0);
    check("rst_level", level, 0);
    check("rst_x", x, 0);
    pulses = 0;
    repeat (10) tick();
    check("rst_nopulse", pulses, 0);

    // Simultaneous push and pop at level 8.
    ready = 0;
    for (int i = 0; i < 8; i++) push(12'(i), 12'(i), 1'b0);
    ready = 1;
    push(12'd300, 12'd400, 1'b1);
    check("pp_level", level, 8);
    repeat (30) tick();

`ifdef VECTOR_CMD_FIFO_PARK_EN
    // Park: one jump to the centre per empty period.
    do_reset();
    ready = 1;
    pulses = 0;
    repeat (300) tick();
    check("park_once", pulses, 1);
    check("park_x", x, 2048);
    check("park_y", y, 2048);
    repeat (1000) tick();
    check("park_no_repeat", pulses, 1);
`else
    do_reset();
    ready = 1;
    pulses = 0;
    repeat (300) tick();
    check("no_park", pulses, 0);
`endif

    // Random traffic, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      reset   = $urandom_range(0, 199) == 0;
      wr_en   = $urandom_range(0, 99) < 45;
      wr_x    = 12'($urandom);
      wr_y    = 12'($urandom);
      wr_draw = 1'($urandom);
      ready   = $urandom_range(0, 99) < 30;
      tick();
    end
    reset = 0; wr_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
